// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image over a valid/ready byte
// stream, writes each little-endian 32-bit word into instruction memory and
// keeps the core held in reset until a frame with a matching XOR checksum
// has been loaded.
module imem_boot_loader #(
    parameter int                 ADDR_W    = 32,
    parameter int                 MAX_WORDS = 256,
    parameter logic [7:0]         MAGIC     = 8'hA5,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [23:0]       word_q;       // first three bytes of the word, LSB in [7:0]
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;
    logic [15:0]       load_count_q;

    logic              accept;
    logic [15:0]       len_d;
    logic [31:0]       word_d;
    logic [15:0]       count_d;
    logic [ADDR_W-1:0] addr_d;

    // The IMEM port is single-ported, so no byte is taken while a word is written.
    assign in_ready = ~imem_we_q;
    assign accept   = in_valid & in_ready;

    assign len_d   = {in_data, len_lo_q};
    assign word_d  = {in_data, word_q};
    assign count_d = load_count_q + 16'd1;
    assign addr_d  = BASE_ADDR + (ADDR_W'(load_count_q) << 2);

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign load_count = load_count_q;

    // Frame parser FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'h00;
            len_q        <= 16'h0000;
            word_q       <= 24'h000000;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'h0000_0000;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            load_count_q <= 16'h0000;
        end else begin
            imem_we_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_IDLE, S_DONE, S_ERR: begin
                        // Anything other than the start byte is line noise here.
                        if (in_data == MAGIC) begin
                            state_q      <= S_LEN0;
                            cpu_hold_q   <= 1'b1;
                            load_done_q  <= 1'b0;
                            load_error_q <= 1'b0;
                            load_count_q <= 16'h0000;
                            csum_q       <= 8'h00;
                            byte_idx_q   <= 2'd0;
                        end
                    end
                    S_LEN0: begin
                        len_lo_q <= in_data;
                        state_q  <= S_LEN1;
                    end
                    S_LEN1: begin
                        len_q <= len_d;
                        if (len_d > 16'(MAX_WORDS)) begin
                            state_q      <= S_ERR;
                            load_error_q <= 1'b1;
                        end else if (len_d == 16'h0000) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum_q     <= csum_q ^ in_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        word_q     <= {in_data, word_q[23:8]};
                        if (byte_idx_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= word_d;
                            imem_addr_q  <= addr_d;
                            load_count_q <= count_d;
                            if (count_d == len_q) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (in_data == csum_q) begin
                            state_q     <= S_DONE;
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            state_q      <= S_ERR;
                            load_error_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: frames are described at the byte level by
// the bench, each byte carries the effect it must have once accepted, and a
// per-cycle compare process checks the loader's outputs against that model.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 32;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [15:0]       load_count;

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .MAGIC     (8'hA5),
        .BASE_ADDR ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What accepting one particular byte must do to the outputs.
    typedef struct {
        bit          start;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
        bit          fin_done;
        bit          fin_err;
    } tag_t;

    localparam tag_t TAG_NONE = '{start: 1'b0, wr: 1'b0, addr: 32'h0, data: 32'h0,
                                  cnt: 16'h0, fin_done: 1'b0, fin_err: 1'b0};

    tag_t        tag_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] fw[$];
    logic [63:0] wlog[$];
    bit          check_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_we;
    logic [31:0] exp_addr, exp_data;
    logic        exp_hold, exp_done, exp_err;
    logic [15:0] exp_count;
    tag_t        mt;

    // Reference model: applies the effect of each accepted byte.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_we    = 1'b0;
            exp_addr  = 32'h0;
            exp_data  = 32'h0;
            exp_hold  = 1'b1;
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            exp_count = 16'h0;
        end else begin
            exp_we = 1'b0;
            if (in_valid && in_ready) begin
                chk("accept_expected", 64'(tag_q.size() > 0), 64'd1);
                if (tag_q.size() > 0) begin
                    mt = tag_q.pop_front();
                    if (mt.start) begin
                        exp_hold  = 1'b1;
                        exp_done  = 1'b0;
                        exp_err   = 1'b0;
                        exp_count = 16'h0;
                    end
                    if (mt.wr) begin
                        exp_we    = 1'b1;
                        exp_addr  = mt.addr;
                        exp_data  = mt.data;
                        exp_count = mt.cnt;
                    end
                    if (mt.fin_done) begin
                        exp_done = 1'b1;
                        exp_hold = 1'b0;
                    end
                    if (mt.fin_err) exp_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_we", 64'(imem_we), 64'(exp_we));
            chk("in_ready", 64'(in_ready), 64'(!exp_we));
            if (exp_we) begin
                chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
                chk("imem_wdata", 64'(imem_wdata), 64'(exp_data));
            end
            if (imem_we) wlog.push_back({imem_addr, imem_wdata});
            chk("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
            chk("load_done", 64'(load_done), 64'(exp_done));
            chk("load_error", 64'(load_error), 64'(exp_err));
            chk("load_count", 64'(load_count), 64'(exp_count));
        end
    end

    task automatic add(input logic [7:0] b, input tag_t t);
        byte_q.push_back(b);
        tag_q.push_back(t);
    endtask

    task automatic add_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            add(b, TAG_NONE);
        end
    endtask

    // Queues one frame built from the words in fw; outcome follows from the XOR rule.
    task automatic build(input logic [15:0] len_field, input bit auto_csum, input logic [7:0] csum_val);
        tag_t       t;
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] cs;
        logic [31:0] w;
        x = 8'h00;
        t = TAG_NONE; t.start = 1'b1;
        add(8'hA5, t);
        add(len_field[7:0], TAG_NONE);
        t = TAG_NONE;
        if (int'(len_field) > MAX_WORDS) t.fin_err = 1'b1;
        add(len_field[15:8], t);
        if (int'(len_field) > MAX_WORDS) return;
        for (int i = 0; i < fw.size(); i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                x = x ^ b;
                t = TAG_NONE;
                if (k == 3) begin
                    t.wr   = 1'b1;
                    t.addr = 32'(4 * i);
                    t.data = w;
                    t.cnt  = 16'(i + 1);
                end
                add(b, t);
            end
        end
        cs = auto_csum ? x : csum_val;
        t = TAG_NONE;
        if (cs == x) t.fin_done = 1'b1;
        else         t.fin_err  = 1'b1;
        add(cs, t);
    endtask

    // Presents one byte with optional idle gaps; returns on the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n && byte_q.size() > 0; i++) send_byte(byte_q.pop_front());
    endtask

    task automatic send_all();
        while (byte_q.size() > 0) send_byte(byte_q.pop_front());
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
        chk({tag, "_err"}, 64'(load_error), 64'd0);
        chk({tag, "_count"}, 64'(load_count), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic set_good_words();
        fw.delete();
        fw.push_back(32'h0000_0013);
        fw.push_back(32'h0010_0093);
    endtask

    initial begin
        int r;
        int nw;
        logic [15:0] lf;

        // Asynchronous reset in the middle of the low phase.
        #2 rst = 1'b0;
        #1 chk_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        // Good frame with leading noise; the XOR of its eight word bytes is 0x90.
        wlog.delete();
        add(8'h00, TAG_NONE);
        add(8'h37, TAG_NONE);
        add(8'hFF, TAG_NONE);
        set_good_words();
        build(16'd2, 1'b0, 8'h90);
        send_all();
        chk("good_done", 64'(load_done), 64'd1);
        chk("good_hold", 64'(cpu_hold), 64'd0);
        chk("good_count", 64'(load_count), 64'd2);
        chk("good_nwrites", 64'(wlog.size()), 64'd2);
        chk("good_w0", (wlog.size() > 0) ? wlog[0] : 64'h0, 64'h0000_0000_0000_0013);
        chk("good_w1", (wlog.size() > 1) ? wlog[1] : 64'h0, 64'h0000_0004_0010_0093);

        // Reload with a bad checksum: hold must come back on the start byte.
        wlog.delete();
        set_good_words();
        build(16'd2, 1'b0, 8'h00);
        send_n(1);
        chk("reload_hold", 64'(cpu_hold), 64'd1);
        chk("reload_done", 64'(load_done), 64'd0);
        send_all();
        chk("badcs_err", 64'(load_error), 64'd1);
        chk("badcs_hold", 64'(cpu_hold), 64'd1);
        chk("badcs_count", 64'(load_count), 64'd2);
        chk("badcs_nwrites", 64'(wlog.size()), 64'd2);

        // Oversize length followed by noise, then an empty frame.
        wlog.delete();
        fw.delete();
        build(16'h0101, 1'b1, 8'h00);
        add_garbage(3);
        send_all();
        chk("over_err", 64'(load_error), 64'd1);
        chk("over_nwrites", 64'(wlog.size()), 64'd0);
        build(16'h0000, 1'b0, 8'h00);
        send_all();
        chk("empty_done", 64'(load_done), 64'd1);
        chk("empty_count", 64'(load_count), 64'd0);
        chk("empty_hold", 64'(cpu_hold), 64'd0);

        // Randomized frames: lengths, data (including start bytes), checksums, noise.
        for (int f = 0; f < 24; f++) begin
            add_garbage($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            fw.delete();
            if (r == 0) begin
                lf = 16'h0000;
            end else if (r == 1) begin
                lf = 16'($urandom_range(MAX_WORDS + 1, 16'hFFFF));
            end else begin
                nw = $urandom_range(1, 8);
                for (int i = 0; i < nw; i++) fw.push_back($urandom);
                if ($urandom_range(0, 2) == 0) fw[0][7:0] = 8'hA5;
                lf = 16'(nw);
            end
            build(lf, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
            send_all();
        end

        // Reset after one of two words has been written.
        set_good_words();
        build(16'd2, 1'b1, 8'h00);
        send_n(8);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_values("midrst");
        byte_q.delete();
        tag_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_after_hold", 64'(cpu_hold), 64'd1);
        chk("midrst_after_count", 64'(load_count), 64'd0);

        // A fresh good frame still loads after the abandoned one.
        set_good_words();
        build(16'd2, 1'b1, 8'h00);
        send_all();
        chk("final_done", 64'(load_done), 64'd1);
        chk("final_count", 64'(load_count), 64'd2);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
